// File: rtl/vc_mem_arb_4to1_pkg.sv
// Shared definitions for the 4:1 memory arbiter: port-ID width, message sizes and helpers.
// Message layouts: req = {type, addr, len, data}, resp = {type, len, data}.
package vc_mem_arb_4to1_pkg;

  localparam int unsigned PORT_ID_SZ = 2;
  localparam int unsigned NUM_PORTS  = 4;

  typedef logic [PORT_ID_SZ-1:0] port_id_t;

  function automatic int unsigned req_msg_sz(input int unsigned addr_sz, input int unsigned data_sz);
    return 1 + addr_sz + $clog2(data_sz / 8) + data_sz;
  endfunction

  function automatic int unsigned resp_msg_sz(input int unsigned data_sz);
    return 1 + $clog2(data_sz / 8) + data_sz;
  endfunction

  // Count register needs one extra bit so that "full" is representable
  function automatic int unsigned cnt_sz(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic port_id_t onehot_to_id(input logic [NUM_PORTS-1:0] oh);
    port_id_t id;
    id = '0;
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      if (oh[i]) id = PORT_ID_SZ'(i);
    end
    return id;
  endfunction

endpackage

// File: rtl/vc_mem_arb_4to1_rr_arb.sv
// Four-way round-robin arbiter with one-hot grant; prio advances past the winner on en.
// Define VC_MEM_ARB_FIXED_PRIO_EN for fixed priority (port 0 highest).
module vc_rr_arb_4
  import vc_mem_arb_4to1_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 en,
  output logic [NUM_PORTS-1:0] gnt
);

  port_id_t prio;
  port_id_t idx;

  // Scan from lowest to highest priority so the highest-priority requester overwrites
  always_comb begin
    gnt = '0;
    idx = prio;
    for (int i = int'(NUM_PORTS) - 1; i >= 0; i--) begin
      idx = prio + PORT_ID_SZ'(i);
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
      end
    end
  end

`ifdef VC_MEM_ARB_FIXED_PRIO_EN
  logic unused_ok;
  assign prio      = '0;
  assign unused_ok = &{1'b0, clk, reset, en};
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      prio <= '0;
    end else if (en) begin
      prio <= onehot_to_id(gnt) + PORT_ID_SZ'(1);
    end
  end
`endif

endmodule

// File: rtl/vc_mem_arb_4to1.sv
// Funnels four memory request/response port pairs onto one in-order memory port.
// Grants are logged in a tag queue used to steer responses; VC_MEM_ARB_FIXED_PRIO_EN selects fixed priority.
module vc_mem_arb_4to1
  import vc_mem_arb_4to1_pkg::*;
#(
  parameter  int unsigned p_addr_sz      = 8,
  parameter  int unsigned p_data_sz      = 32,
  parameter  int unsigned p_max_inflight = 4,
  localparam int unsigned c_req_msg_sz   = req_msg_sz(p_addr_sz, p_data_sz),
  localparam int unsigned c_resp_msg_sz  = resp_msg_sz(p_data_sz)
) (
  input  logic                     clk,
  input  logic                     reset,

  input  logic                     memreq0_val,
  output logic                     memreq0_rdy,
  input  logic [c_req_msg_sz-1:0]  memreq0_msg,
  input  logic                     memreq1_val,
  output logic                     memreq1_rdy,
  input  logic [c_req_msg_sz-1:0]  memreq1_msg,
  input  logic                     memreq2_val,
  output logic                     memreq2_rdy,
  input  logic [c_req_msg_sz-1:0]  memreq2_msg,
  input  logic                     memreq3_val,
  output logic                     memreq3_rdy,
  input  logic [c_req_msg_sz-1:0]  memreq3_msg,

  output logic                     memresp0_val,
  input  logic                     memresp0_rdy,
  output logic [c_resp_msg_sz-1:0] memresp0_msg,
  output logic                     memresp1_val,
  input  logic                     memresp1_rdy,
  output logic [c_resp_msg_sz-1:0] memresp1_msg,
  output logic                     memresp2_val,
  input  logic                     memresp2_rdy,
  output logic [c_resp_msg_sz-1:0] memresp2_msg,
  output logic                     memresp3_val,
  input  logic                     memresp3_rdy,
  output logic [c_resp_msg_sz-1:0] memresp3_msg,

  output logic                     memreq_val,
  input  logic                     memreq_rdy,
  output logic [c_req_msg_sz-1:0]  memreq_msg,

  input  logic                     memresp_val,
  output logic                     memresp_rdy,
  input  logic [c_resp_msg_sz-1:0] memresp_msg
);

  localparam int unsigned PTR_SZ = $clog2(p_max_inflight);
  localparam int unsigned CNT_SZ = cnt_sz(p_max_inflight);

  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] gnt;
  logic [NUM_PORTS-1:0] resp_rdy_vec;
  port_id_t             gnt_id;
  port_id_t             head_id;
  port_id_t             tags [p_max_inflight];
  logic [PTR_SZ-1:0]    head;
  logic [PTR_SZ-1:0]    tail;
  logic [CNT_SZ-1:0]    count;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;

  // Request path: full blocks issue even when a pop lands in the same cycle
  assign req        = {memreq3_val, memreq2_val, memreq1_val, memreq0_val};
  assign full       = (count == CNT_SZ'(p_max_inflight));
  assign empty      = (count == '0);
  assign memreq_val = (|req) & ~full;
  assign push       = memreq_val & memreq_rdy;
  assign gnt_id     = onehot_to_id(gnt);

  vc_rr_arb_4 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .en    (push),
    .gnt   (gnt)
  );

  always_comb begin
    memreq_msg = memreq0_msg;
    case (gnt_id)
      2'd1:    memreq_msg = memreq1_msg;
      2'd2:    memreq_msg = memreq2_msg;
      2'd3:    memreq_msg = memreq3_msg;
      default: memreq_msg = memreq0_msg;
    endcase
  end

  assign memreq0_rdy = gnt[0] & push;
  assign memreq1_rdy = gnt[1] & push;
  assign memreq2_rdy = gnt[2] & push;
  assign memreq3_rdy = gnt[3] & push;

  // Response path: steer to the port recorded at the queue head
  assign head_id      = tags[head];
  assign resp_rdy_vec = {memresp3_rdy, memresp2_rdy, memresp1_rdy, memresp0_rdy};
  assign memresp_rdy  = ~empty & resp_rdy_vec[head_id];
  assign pop          = memresp_val & memresp_rdy;

  assign memresp0_val = ~empty & memresp_val & (head_id == 2'd0);
  assign memresp1_val = ~empty & memresp_val & (head_id == 2'd1);
  assign memresp2_val = ~empty & memresp_val & (head_id == 2'd2);
  assign memresp3_val = ~empty & memresp_val & (head_id == 2'd3);

  assign memresp0_msg = memresp_msg;
  assign memresp1_msg = memresp_msg;
  assign memresp2_msg = memresp_msg;
  assign memresp3_msg = memresp_msg;

  always_ff @(posedge clk) begin
    if (push) tags[tail] <= gnt_id;
  end

  // Tag queue pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_SZ'(1);
      if (pop)  head <= head + PTR_SZ'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_SZ'(1);
        2'b01:   count <= count - CNT_SZ'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_vc_mem_arb_4to1.sv
// Scoreboard bench for vc_mem_arb_4to1: directed request sets, a bench-side in-order memory,
// and grant/response monitors checking against queued expectations.
module tb_vc_mem_arb_4to1;
  import vc_mem_arb_4to1_pkg::*;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned RQ = req_msg_sz(AW, DW);
  localparam int unsigned RS = resp_msg_sz(DW);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          rq_val [4];
  logic          rq_rdy [4];
  logic [RQ-1:0] rq_msg [4];
  logic          rs_val [4];
  logic          rs_rdy [4];
  logic [RS-1:0] rs_msg [4];
  logic          rs_rdy_base [4];
  logic          memreq_val, memreq_rdy, memresp_val, memresp_rdy;
  logic [RQ-1:0] memreq_msg;
  logic [RS-1:0] memresp_msg;

  int vectors = 0;
  int miscompares = 0;
  int n_req_fires = 0;

  typedef logic [7:0] aq_t[$];
  typedef struct packed { logic [1:0] port; logic [7:0] addr; } gexp_t;
  typedef struct packed { logic [1:0] port; logic [31:0] data; } rexp_t;

  aq_t           pend [4];
  gexp_t         exp_gnt[$];
  rexp_t         resp_exp[$];
  logic [RS-1:0] mq[$];
  logic          mem_hold = 1'b0;
  logic          mem_force = 1'b0;
  logic          rand_en = 1'b0;

  vc_mem_arb_4to1 dut (
    .clk(clk), .reset(reset),
    .memreq0_val(rq_val[0]), .memreq0_rdy(rq_rdy[0]), .memreq0_msg(rq_msg[0]),
    .memreq1_val(rq_val[1]), .memreq1_rdy(rq_rdy[1]), .memreq1_msg(rq_msg[1]),
    .memreq2_val(rq_val[2]), .memreq2_rdy(rq_rdy[2]), .memreq2_msg(rq_msg[2]),
    .memreq3_val(rq_val[3]), .memreq3_rdy(rq_rdy[3]), .memreq3_msg(rq_msg[3]),
    .memresp0_val(rs_val[0]), .memresp0_rdy(rs_rdy[0]), .memresp0_msg(rs_msg[0]),
    .memresp1_val(rs_val[1]), .memresp1_rdy(rs_rdy[1]), .memresp1_msg(rs_msg[1]),
    .memresp2_val(rs_val[2]), .memresp2_rdy(rs_rdy[2]), .memresp2_msg(rs_msg[2]),
    .memresp3_val(rs_val[3]), .memresp3_rdy(rs_rdy[3]), .memresp3_msg(rs_msg[3]),
    .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_msg(memreq_msg),
    .memresp_val(memresp_val), .memresp_rdy(memresp_rdy), .memresp_msg(memresp_msg)
  );

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return (a == 8'h10) ? 32'hCAFE0000 : {8'hA5, a, ~a, 8'h5A};
  endfunction

  function automatic logic [RQ-1:0] mk_req(input logic [7:0] a);
    return RQ'({1'b0, a, 2'b00, 32'h0});
  endfunction

  function automatic logic [RS-1:0] mk_resp(input logic [31:0] d);
    return RS'({1'b0, 2'b00, d});
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic wait_fires(input int target);
    int cyc = 0;
    while (n_req_fires < target && cyc < 200) begin
      @(posedge clk);
      cyc++;
    end
    if (n_req_fires < target) begin
      vectors++;
      miscompares++;
      $display("FAIL req_fire_timeout: got %0d fires, want %0d", n_req_fires, target);
    end
  endtask

  task automatic wait_idle();
    int cyc = 0;
    while ((pend[0].size() + pend[1].size() + pend[2].size() + pend[3].size() +
            exp_gnt.size() + resp_exp.size() + mq.size()) != 0 && cyc < 3000) begin
      @(posedge clk);
      cyc++;
    end
    if (cyc >= 3000) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d grants and %0d responses pending, want 0",
               exp_gnt.size(), resp_exp.size());
    end
  endtask

  task automatic issue_one(input int p, input logic [7:0] a);
    int base;
    base = n_req_fires;
    exp_gnt.push_back({2'(p), a});
    pend[p].push_back(a);
    wait_fires(base + 1);
  endtask

  // Client drivers: request heads and response readiness
  initial forever begin
    @(posedge clk);
    #2;
    for (int p = 0; p < 4; p++) begin
      rq_val[p] = (pend[p].size() > 0);
      rq_msg[p] = (pend[p].size() > 0) ? mk_req(pend[p][0]) : '0;
      rs_rdy[p] = rand_en ? ($urandom_range(0, 3) != 0) : rs_rdy_base[p];
    end
  end

  // In-order memory with at least one cycle of latency
  initial begin : mem_model
    logic       rf, pf;
    logic [7:0] a;
    forever begin
      @(negedge clk);
      rf = memreq_val && memreq_rdy;
      pf = memresp_val && memresp_rdy;
      a  = memreq_msg[RQ-2 -: 8];
      @(posedge clk);
      #3;
      if (pf && mq.size() > 0) mq.delete(0);
      if (rf) mq.push_back(mk_resp(mem_word(a)));
      memresp_val = mem_force || (mq.size() > 0 && !mem_hold && (!rand_en || $urandom_range(0, 2) == 0));
      memresp_msg = (mq.size() > 0) ? mq[0] : '0;
    end
  end

  // Request monitor: grant order and pass-through
  initial begin : req_mon
    int    fp, nf;
    gexp_t g;
    forever begin
      @(negedge clk);
      if (memreq_val && memreq_rdy) begin
        fp = -1;
        nf = 0;
        for (int p = 0; p < 4; p++) begin
          if (rq_val[p] && rq_rdy[p]) begin
            fp = p;
            nf++;
          end
        end
        n_req_fires++;
        check("grant_onehot", 64'(nf), 64'd1);
        if (exp_gnt.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_grant: got port %0d, want none", fp);
        end else begin
          g = exp_gnt.pop_front();
          check("grant_port", 64'(fp), 64'(g.port));
          check("req_passthru", 64'(memreq_msg), 64'(mk_req(g.addr)));
          resp_exp.push_back({g.port, mem_word(g.addr)});
        end
        if (fp >= 0 && pend[fp].size() > 0) pend[fp].delete(0);
      end
    end
  end

  // Response monitor: steering and data
  initial begin : resp_mon
    int    nv;
    rexp_t r;
    forever begin
      @(negedge clk);
      nv = 0;
      for (int p = 0; p < 4; p++) if (rs_val[p]) nv++;
      if (nv > 0) check("resp_val_onehot", 64'(nv), 64'd1);
      for (int p = 0; p < 4; p++) begin
        if (rs_val[p] && rs_rdy[p]) begin
          if (resp_exp.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_resp: got port %0d, want none", p);
          end else begin
            r = resp_exp.pop_front();
            check("resp_port", 64'(p), 64'(r.port));
            check("resp_data", 64'(rs_msg[p][31:0]), 64'(r.data));
          end
        end
      end
    end
  end

  initial begin
    int base;
    reset      = 1'b1;
    memreq_rdy = 1'b1;
    mem_force  = 1'b1;
    for (int p = 0; p < 4; p++) rs_rdy_base[p] = 1'b1;

    // Reset state, with memresp_val forced high to expose any leakage
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_memreq_val", 64'(memreq_val), 64'd0);
    check("rst_memresp_rdy", 64'(memresp_rdy), 64'd0);
    for (int p = 0; p < 4; p++) begin
      check("rst_memreq_rdy", 64'(rq_rdy[p]), 64'd0);
      check("rst_memresp_val", 64'(rs_val[p]), 64'd0);
    end
    @(posedge clk);
    #1;
    reset     = 1'b0;
    mem_force = 1'b0;

    // All four ports continuously valid
`ifdef VC_MEM_ARB_FIXED_PRIO_EN
    for (int p = 0; p < 4; p++)
      for (int i = 0; i < 8; i++) exp_gnt.push_back({2'(p), 8'(p * 64 + i)});
`else
    for (int i = 0; i < 8; i++)
      for (int p = 0; p < 4; p++) exp_gnt.push_back({2'(p), 8'(p * 64 + i)});
`endif
    for (int p = 0; p < 4; p++)
      for (int i = 0; i < 8; i++) pend[p].push_back(8'(p * 64 + i));
    wait_idle();

    // Single port 2 read of 0x10
    #1;
    issue_one(2, 8'h10);
    wait_idle();

    // Queue full: four outstanding, fifth waits until a pop has completed
    #1;
    mem_hold = 1'b1;
    base = n_req_fires;
    for (int i = 0; i < 5; i++) begin
      exp_gnt.push_back({2'd0, 8'(8'h20 + i)});
      pend[0].push_back(8'(8'h20 + i));
    end
    wait_fires(base + 4);
    @(negedge clk);
    check("full_memreq_val", 64'(memreq_val), 64'd0);
    check("full_memreq0_rdy", 64'(rq_rdy[0]), 64'd0);
    check("full_count", 64'(dut.count), 64'd4);
    @(posedge clk);
    #1;
    mem_hold = 1'b0;
    @(negedge clk);
    check("full_pop_memreq_val", 64'(memreq_val), 64'd0);
    check("full_pop_memresp_rdy", 64'(memresp_rdy), 64'd1);
    @(negedge clk);
    check("after_pop_memreq0_rdy", 64'(rq_rdy[0]), 64'd1);
    wait_idle();

    // Response back-pressure on port 1
    #1;
    rs_rdy_base[1] = 1'b0;
    issue_one(1, 8'h30);
    @(negedge clk);
    check("bp_memresp_rdy", 64'(memresp_rdy), 64'd0);
    check("bp_memresp1_val", 64'(rs_val[1]), 64'd1);
    for (int p = 0; p < 4; p++) check("bp_resp_msg", 64'(rs_msg[p]), 64'(mk_resp(32'hA530CF5A)));
    @(negedge clk);
    check("bp_hold_memresp_rdy", 64'(memresp_rdy), 64'd0);
    check("bp_hold_memresp1_val", 64'(rs_val[1]), 64'd1);
    @(posedge clk);
    #1;
    rs_rdy_base[1] = 1'b1;
    @(negedge clk);
    check("bp_release_memresp_rdy", 64'(memresp_rdy), 64'd1);
    wait_idle();

    // Simultaneous push and pop with two outstanding
    #1;
    mem_hold = 1'b1;
    issue_one(0, 8'h40);
    issue_one(1, 8'h41);
    #1;
    mem_hold = 1'b0;
    exp_gnt.push_back({2'd2, 8'h42});
    pend[2].push_back(8'h42);
    @(negedge clk);
    check("simul_push", 64'(memreq_val && memreq_rdy), 64'd1);
    check("simul_pop", 64'(memresp_val && memresp_rdy), 64'd1);
    @(negedge clk);
    check("simul_count", 64'(dut.count), 64'd2);
    wait_idle();

    // Reset with three outstanding tags
    #1;
    mem_hold = 1'b1;
    issue_one(1, 8'h51);
    issue_one(2, 8'h52);
    issue_one(3, 8'h53);
    #1;
    reset     = 1'b1;
    mem_force = 1'b1;
    for (int p = 0; p < 4; p++) rs_rdy_base[p] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    resp_exp.delete();
    mq.delete();
    @(negedge clk);
    check("midrst_memresp_rdy", 64'(memresp_rdy), 64'd0);
    check("midrst_count", 64'(dut.count), 64'd0);
    for (int p = 0; p < 4; p++) check("midrst_memresp_val", 64'(rs_val[p]), 64'd0);
    @(posedge clk);
    #1;
    mem_force = 1'b0;
    mem_hold  = 1'b0;
    for (int p = 0; p < 4; p++) rs_rdy_base[p] = 1'b1;
    exp_gnt.push_back({2'd0, 8'h60});
    exp_gnt.push_back({2'd3, 8'h63});
    pend[3].push_back(8'h63);
    pend[0].push_back(8'h60);
    wait_idle();

    // Random memory and client delays, all ports busy
    #1;
    rand_en = 1'b1;
`ifdef VC_MEM_ARB_FIXED_PRIO_EN
    for (int p = 0; p < 4; p++)
      for (int i = 0; i < 25; i++) exp_gnt.push_back({2'(p), 8'(p * 64 + i)});
`else
    for (int i = 0; i < 25; i++)
      for (int p = 0; p < 4; p++) exp_gnt.push_back({2'(p), 8'(p * 64 + i)});
`endif
    for (int p = 0; p < 4; p++)
      for (int i = 0; i < 25; i++) pend[p].push_back(8'(p * 64 + i));
    wait_idle();
    rand_en = 1'b0;
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
